dff_share_arb: RTL

Round-robin arbiter and write sequencer for one shared W-bit register built from resettable D flip-flops. Up to N requesters compete for write access; the block grants one at a time, latches the winner's data into the shared register and acknowledges the write. It sits between client logic and the shared register, and is the only writer of that register.

---
 rtl/dff_arb_pkg.sv | 10 +
 rtl/dff_share_arb_rr_pick.sv | 30 +++
 rtl/dff_share_arb.sv | 106 ++++++++++
 3 files changed

// File: rtl/dff_arb_pkg.sv
// Shared definitions for the dff_share_arb register arbiter.
package dff_arb_pkg;
   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      WRITE = 2'd2
   } state_t;
endpackage

// File: rtl/dff_share_arb_rr_pick.sv
// rr_pick: combinational round-robin picker; searches ptr+1, ptr+2, ... modulo N.
module rr_pick #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  pick,
   output logic [IW-1:0] idx
);
   localparam int unsigned NU = N;

   always_comb begin
      logic        found;
      int unsigned j;
      logic [IW-1:0] jj;
      pick  = '0;
      idx   = '0;
      found = 1'b0;
      for (int unsigned k = 1; k <= NU; k++) begin
         j  = (32'(ptr) + k) % NU;
         jj = IW'(j);
         if (!found && req[jj]) begin
            found    = 1'b1;
            pick[jj] = 1'b1;
            idx      = jj;
         end
      end
   end
endmodule

// File: rtl/dff_share_arb.sv
// dff_share_arb: round-robin write sequencer for one shared W-bit register.
// Optional hold-grant feature guarded by DFF_ARB_LOCK_EN.
module dff_share_arb
   import dff_arb_pkg::*;
#(
   parameter int N = 4,
   parameter int W = 8
) (
   input  logic                 clk,
   input  logic                 res,
   input  logic [N-1:0]         req,
   input  logic [N*W-1:0]       wdata,
`ifdef DFF_ARB_LOCK_EN
   input  logic [N-1:0]         lock,
`endif
   output logic [N-1:0]         gnt,
   output logic [N-1:0]         ack,
   output logic [W-1:0]         q,
   output logic [$clog2(N)-1:0] owner,
   output logic                 busy
);
   localparam int IW = $clog2(N);

   state_t        state, state_n;
   logic [IW-1:0] ptr, gidx, pick_idx;
   logic [N-1:0]  pick;
   logic          do_grant, do_write, do_clr, hold;

   rr_pick #(.N(N), .IW(IW)) u_pick (
      .req  (req),
      .ptr  (ptr),
      .pick (pick),
      .idx  (pick_idx)
   );

`ifdef DFF_ARB_LOCK_EN
   assign hold = lock[gidx];
`else
   assign hold = 1'b0;
`endif

   assign busy = (state != IDLE);

   always_comb begin
      state_n  = state;
      do_grant = 1'b0;
      do_write = 1'b0;
      do_clr   = 1'b0;
      case (state)
         IDLE: begin
            if (|req) begin
               state_n  = GRANT;
               do_grant = 1'b1;
            end
         end
         GRANT: begin
            if (req[gidx]) begin
               state_n  = WRITE;
               do_write = 1'b1;
            end else begin
               state_n = IDLE;
               do_clr  = 1'b1;
            end
         end
         WRITE: begin
            // a held lock re-enters GRANT with the same grant, skipping arbitration
            if (hold) begin
               state_n = GRANT;
            end else begin
               state_n = IDLE;
               do_clr  = 1'b1;
            end
         end
         default: begin
            state_n = IDLE;
            do_clr  = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         state <= IDLE;
         gnt   <= '0;
         ack   <= '0;
         q     <= '0;
         owner <= '0;
         gidx  <= '0;
         ptr   <= IW'(N - 1);
      end else begin
         state <= state_n;
         ack   <= '0;
         if (do_grant) begin
            gnt  <= pick;
            gidx <= pick_idx;
         end
         if (do_clr) gnt <= '0;
         if (do_write) begin
            ack   <= gnt;
            q     <= wdata[32'(gidx) * W +: W];
            owner <= gidx;
            ptr   <= gidx;
         end
      end
   end
endmodule
